// File: rtl/fetch_buffer.sv
// Circular FIFO of {pc, inst} pairs between the fetch path and decode.
// Stalls the program counter when full; a redirect flush empties it in one cycle.
module fetch_buffer #(
   parameter int          DEPTH  = 4,
   parameter int          ADDR_W = 64,
   parameter int          INST_W = 32,
   parameter logic [31:0] NOP    = 32'h0000_0013
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       flush,
   input  logic                       fetch_valid,
   input  logic [ADDR_W-1:0]          fetch_pc,
   input  logic [INST_W-1:0]          fetch_inst,
   output logic                       stall,
   input  logic                       dec_ready,
   output logic                       dec_valid,
   output logic [ADDR_W-1:0]          dec_pc,
   output logic [INST_W-1:0]          dec_inst,
   output logic [$clog2(DEPTH+1)-1:0] count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   logic [ADDR_W-1:0] pc_mem   [DEPTH];
   logic [INST_W-1:0] inst_mem [DEPTH];
   logic [PW-1:0]     wr_ptr;
   logic [PW-1:0]     rd_ptr;
   logic              push;
   logic              pop;

   assign push      = fetch_valid && (count != FULL) && !flush;
   assign pop       = dec_valid && dec_ready && !flush;
   assign dec_valid = (count != '0);
   assign stall     = (count == FULL);
   assign dec_pc    = dec_valid ? pc_mem[rd_ptr] : '0;
   assign dec_inst  = dec_valid ? inst_mem[rd_ptr] : INST_W'(NOP);

   always_ff @(posedge clk) begin
      if (reset || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop)  rd_ptr <= rd_ptr + PW'(1);
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // Storage needs no reset: an entry is only read after it has been written.
   always_ff @(posedge clk) begin
      if (!reset && push) begin
         pc_mem[wr_ptr]   <= fetch_pc;
         inst_mem[wr_ptr] <= fetch_inst;
      end
   end

endmodule

// File: tb/tb_fetch_buffer.sv
// Directed self-checking bench for fetch_buffer (DEPTH=4).
module tb_fetch_buffer;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        reset, flush, fetch_valid, dec_ready;
   logic [63:0] fetch_pc;
   logic [31:0] fetch_inst;
   logic        stall, dec_valid;
   logic [63:0] dec_pc;
   logic [31:0] dec_inst;
   logic [2:0]  count;

   int total = 0;
   int fails = 0;

   fetch_buffer dut (
      .clk(clk), .reset(reset), .flush(flush),
      .fetch_valid(fetch_valid), .fetch_pc(fetch_pc), .fetch_inst(fetch_inst),
      .stall(stall), .dec_ready(dec_ready), .dec_valid(dec_valid),
      .dec_pc(dec_pc), .dec_inst(dec_inst), .count(count)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] inst_of(input logic [63:0] pc);
      return 32'h00C0_0033 + pc[31:0];
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic present(input logic v, input logic [63:0] pc);
      fetch_valid = v;
      fetch_pc    = pc;
      fetch_inst  = inst_of(pc);
   endtask

   initial begin
      reset = 1'b1; flush = 1'b0; dec_ready = 1'b0;
      present(1'b1, 64'h50);
      step();
      step();
      chk("rst_count", 64'(count), 64'd0);
      chk("rst_valid", 64'(dec_valid), 64'd0);
      chk("rst_inst", 64'(dec_inst), 64'(NOP));
      chk("rst_pc", dec_pc, 64'd0);
      chk("rst_stall", 64'(stall), 64'd0);
      reset = 1'b0;

      // fill to full with decode blocked
      for (int i = 0; i < 4; i++) begin
         present(1'b1, 64'(4 * i));
         step();
         chk("fill_count", 64'(count), 64'(i + 1));
         chk("fill_stall", 64'(stall), (i == 3) ? 64'd1 : 64'd0);
      end
      present(1'b1, 64'h10);
      step();
      chk("full_count", 64'(count), 64'd4);
      chk("full_stall", 64'(stall), 64'd1);
      chk("full_head_pc", dec_pc, 64'h0);
      chk("full_head_inst", 64'(dec_inst), 64'(inst_of(64'h0)));

      // one pop frees a slot; 0x10 accepted on the following cycle
      dec_ready = 1'b1;
      step();
      chk("pop_count", 64'(count), 64'd3);
      chk("pop_stall", 64'(stall), 64'd0);
      chk("pop_head", dec_pc, 64'h4);
      dec_ready = 1'b0;
      step();
      chk("refill_count", 64'(count), 64'd4);
      chk("refill_stall", 64'(stall), 64'd1);
      present(1'b0, 64'h0);
      dec_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         chk("drain_valid", 64'(dec_valid), 64'd1);
         chk("drain_pc", dec_pc, 64'(4 + 4 * i));
         chk("drain_inst", 64'(dec_inst), 64'(inst_of(64'(4 + 4 * i))));
         step();
      end
      chk("drain_count", 64'(count), 64'd0);
      chk("drain_valid_end", 64'(dec_valid), 64'd0);

      // steady push+pop at count=2 across pointer wrap
      dec_ready = 1'b0;
      present(1'b1, 64'h20); step();
      present(1'b1, 64'h24); step();
      chk("stream_pre_count", 64'(count), 64'd2);
      dec_ready = 1'b1;
      for (int k = 0; k < 10; k++) begin
         chk("stream_pc", dec_pc, 64'(32'h20 + 4 * k));
         present(1'b1, 64'(32'h28 + 4 * k));
         step();
         chk("stream_count", 64'(count), 64'd2);
      end
      chk("stream_head", dec_pc, 64'h48);

      dec_ready = 1'b0;
      present(1'b1, 64'h50);
      step();
      chk("preflush_count", 64'(count), 64'd3);

      // flush wins over simultaneous push and pop
      flush = 1'b1; dec_ready = 1'b1;
      present(1'b1, 64'h100);
      step();
      flush = 1'b0; dec_ready = 1'b0;
      chk("flush_count", 64'(count), 64'd0);
      chk("flush_valid", 64'(dec_valid), 64'd0);
      chk("flush_stall", 64'(stall), 64'd0);
      chk("flush_inst", 64'(dec_inst), 64'(NOP));
      present(1'b1, 64'h200);
      step();
      present(1'b0, 64'h0);
      chk("postflush_count", 64'(count), 64'd1);
      chk("postflush_pc", dec_pc, 64'h200);
      dec_ready = 1'b1;
      step();
      chk("postflush_drain", 64'(count), 64'd0);

      // pops on an empty buffer do nothing
      for (int i = 0; i < 3; i++) begin
         step();
         chk("empty_count", 64'(count), 64'd0);
         chk("empty_pc", dec_pc, 64'd0);
         chk("empty_inst", 64'(dec_inst), 64'(NOP));
      end

      // reset mid-operation, together with flush
      dec_ready = 1'b0;
      present(1'b1, 64'h300); step();
      present(1'b1, 64'h304); step();
      chk("pre_reset_count", 64'(count), 64'd2);
      reset = 1'b1; flush = 1'b1;
      step();
      reset = 1'b0; flush = 1'b0;
      present(1'b0, 64'h0);
      chk("midreset_count", 64'(count), 64'd0);
      chk("midreset_valid", 64'(dec_valid), 64'd0);
      present(1'b1, 64'h400);
      step();
      present(1'b0, 64'h0);
      chk("postreset_pc", dec_pc, 64'h400);
      chk("postreset_count", 64'(count), 64'd1);

      $display("%0d/%0d checks passed", total - fails, total);
      $finish;
   end

endmodule

// File: doc/fetch_buffer.md
# fetch_buffer

Decoupling queue between the program counter/instruction-memory fetch path and the decode stage of the 64-bit pipelined core. It captures each fetched {PC, instruction} pair into a small circular FIFO and presents the oldest entry to decode under a valid/ready handshake. When full it raises `stall` back to the program counter so the PC holds and the same pair is re-presented. A branch redirect flushes every buffered entry in one cycle.

## Interface
- `DEPTH`, 4: number of entries; power of two, ≥ 2.
- `ADDR_W`, 64: PC width.
- `INST_W`, 32: instruction width.
- `NOP`, 32'h0000_0013: encoding driven on `dec_inst` when no entry is valid (addi x0,x0,0).

- `clk`  in  1  rising-edge clock; single clock domain.
- `reset`  in  1  synchronous, active-high.
- `flush`  in  1  branch/jump redirect; discards all entries.
- `fetch_valid`  in  1  `fetch_pc`/`fetch_inst` carry a fetched pair this cycle.
- `fetch_pc`  in  ADDR_W  PC of the fetched instruction (program counter's PC_out).
- `fetch_inst`  in  INST_W  instruction word read at `fetch_pc`.
- `stall`  out  1  to program counter's `stall`; high ⇔ buffer full.
- `dec_ready`  in  1  decode accepts the head entry this cycle.
- `dec_valid`  out  1  head entry valid.
- `dec_pc`  out  ADDR_W  PC of head entry; 0 when empty.
- `dec_inst`  out  INST_W  instruction of head entry; `NOP` when empty.
- `count`  out  $clog2(DEPTH+1)  occupied entries, 0..DEPTH.

## Operation
- Storage: DEPTH-entry arrays for PC and instruction; write pointer `wr_ptr`, read pointer `rd_ptr`, each $clog2(DEPTH) bits, wrapping modulo DEPTH; occupancy held in `count` register.
- push = `fetch_valid` && (`count` != DEPTH) && !`flush`; writes pair at `wr_ptr`, `wr_ptr` += 1.
- pop = `dec_valid` && `dec_ready` && !`flush`; `rd_ptr` += 1.
- `count` next: +1 on push only, −1 on pop only, unchanged on both or neither.
- `dec_valid` = (`count` != 0); `dec_pc`/`dec_inst` = entry at `rd_ptr` when valid, else 0 / `NOP`.
- `stall` = (`count` == DEPTH); combinational from registered `count`, no dependence on `dec_ready` (no full-and-pop bypass).
- Priority per edge: `reset` > `flush` > push/pop.
- `flush`: `count`←0, `rd_ptr`←0, `wr_ptr`←0; any `fetch_valid` pair or `dec_ready` pop in the same cycle is ignored. Array contents are don't-care.
- `reset`: same as flush; all outputs take reset values below at the edge.
- Ordering: entries leave in exact arrival order; no entry duplicated or dropped except by flush/reset.

## Timing
- Reset values: `dec_valid`=0, `dec_pc`=0, `dec_inst`=`NOP`, `stall`=0, `count`=0.
- Latency: pair pushed at edge N is on `dec_*` with `dec_valid`=1 after edge N when buffer was empty; no same-cycle fetch-to-decode bypass.
- Full: push in cycle with `count`=DEPTH−1 → `stall`=1 after that edge; program counter holds; the pair presented while `stall`=1 is not accepted and is re-presented once `stall` drops (one cycle after the first pop).
- Empty: `dec_ready` with `count`=0 has no effect; `count` never underflows.
- Wrap-around: pointers pass DEPTH−1 → 0 with no bubble.
- Flush mid-stream: `dec_valid`=0 and `stall`=0 in the cycle after the flush edge; next push lands in entry 0.
- Reset mid-operation: identical to flush; takes precedence over a simultaneous flush.

## Test plan
- Reset with `fetch_valid`=1 held → `count`=0, `dec_valid`=0, `dec_inst`=0x00000013, `stall`=0 after the reset edge.
- Push PCs 0x0,0x4,0x8,0xC with `dec_ready`=0 → `count` 1,2,3,4; `stall`=1 after 4th edge; 5th pair (0x10) not stored; `dec_pc`=0x0.
- From full, `dec_ready`=1 one cycle → `dec_pc` advances to 0x4, `stall`=0 next cycle, re-presented 0x10 accepted; drain yields 0x4,0x8,0xC,0x10 in order.
- Continuous push+pop for 10 cycles with `count`=2 → `count` stays 2, pointers wrap, output PCs strictly sequential with +4 stride, no bubble.
- `flush` with `count`=3 plus simultaneous `fetch_valid` (PC 0x100) and `dec_ready` → `count`=0, `dec_valid`=0 next cycle; following push of PC 0x200 appears as next `dec_pc`, 0x100 never appears.
- Empty buffer, `dec_ready`=1 for 3 cycles → `count` stays 0, `dec_pc`=0, `dec_inst`=0x00000013.
